// File: rtl/dispensador_bandeja.sv
// Tray-side model of the cork dispenser: moves corks from stock to tray in timed batches, flags tray/stock levels.
// Latency: CR/BZ/ED/liberando are decodes of registered state; first cork lands DISPENSE_CYCLES edges after a batch starts.
// Backpressure: AD is ignored while stock is empty or the tray is full; a started batch always runs to completion.
module dispensador_bandeja #(
  parameter int TRAY_W          = 5,
  parameter int STOCK_W         = 7,
  parameter int TRAY_MAX        = 16,
  parameter int BATCH           = 10,
  parameter int LOW_LEVEL       = 5,
  parameter int DISPENSE_CYCLES = 4,
  parameter int STOCK_INIT      = 50,
  parameter int STOCK_MAX       = 99
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               AD,
  input  logic               rolha_usada,
  input  logic               reabastecer,
  input  logic [STOCK_W-1:0] carga,
  output logic               CR,
  output logic               BZ,
  output logic               ED,
  output logic               liberando,
  output logic               erro_consumo,
  output logic [TRAY_W-1:0]  bandeja,
  output logic [STOCK_W-1:0] estoque
);

  // Timer only needs to count up to DISPENSE_CYCLES-1; keep at least one bit.
  localparam int TMR_W  = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam int LOTE_W = $clog2(BATCH + 1);

  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(DISPENSE_CYCLES - 1);
  localparam logic [LOTE_W-1:0]  LOTE_FIM   = LOTE_W'(BATCH);
  localparam logic [TRAY_W-1:0]  TRAY_FULL  = TRAY_W'(TRAY_MAX);
  localparam logic [TRAY_W-1:0]  TRAY_LOW   = TRAY_W'(LOW_LEVEL);
  localparam logic [STOCK_W-1:0] STOCK_RST  = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] STOCK_TOP  = STOCK_W'(STOCK_MAX);
  localparam logic [STOCK_W:0]   STOCK_SAT  = (STOCK_W + 1)'(STOCK_MAX);

  // Encoding 11 is unused and treated exactly like OCIOSO.
  typedef enum logic [1:0] {
    OCIOSO        = 2'b00,
    LIBERANDO     = 2'b01,
    AGUARDA_BAIXA = 2'b10,
    RESERVADO     = 2'b11
  } estado_t;

  estado_t             estado, estado_n;
  logic [TMR_W-1:0]    timer, timer_n;
  logic [LOTE_W-1:0]   lote, lote_n, lote_inc;
  logic [TRAY_W-1:0]   bandeja_n;
  logic [STOCK_W-1:0]  estoque_n;
  logic [STOCK_W:0]    soma_estoque;
  logic                pode_liberar;
  logic                fim_tempo;
  logic                transfere;
  logic                consome;
  logic                erro_n;

  // Datapath: transfer/consume/refill arithmetic, all against current register values.
  always_comb begin
    pode_liberar = (estoque != '0) && (bandeja < TRAY_FULL);
    fim_tempo    = (estado == LIBERANDO) && (timer == TMR_LAST);
    // The guard keeps the counters from wrapping even if the FSM were ever out of step.
    transfere    = fim_tempo && pode_liberar;
    consome      = rolha_usada && (bandeja != '0);
    erro_n       = rolha_usada && (bandeja == '0);
    lote_inc     = lote + LOTE_W'(1);

    // Transfer and consume on the same edge cancel; consume on an empty tray is dropped.
    bandeja_n    = bandeja + TRAY_W'(transfere) - TRAY_W'(consome);

    // One extra bit so estoque + carga cannot overflow before saturation.
    soma_estoque = {1'b0, estoque} - (STOCK_W + 1)'(transfere)
                 + (reabastecer ? {1'b0, carga} : '0);
    estoque_n    = (soma_estoque > STOCK_SAT) ? STOCK_TOP : soma_estoque[STOCK_W-1:0];
  end

  // Next-state logic: one AD request yields exactly one batch.
  always_comb begin
    estado_n = estado;
    timer_n  = timer;
    lote_n   = lote;
    case (estado)
      LIBERANDO: begin
        if (fim_tempo) begin
          timer_n = '0;
          if (transfere) begin
            lote_n = lote_inc;
          end
          // Batch ends on full batch, full tray or empty stock (post-update values).
          if (!transfere || (lote_inc == LOTE_FIM) ||
              (bandeja_n == TRAY_FULL) || (estoque_n == '0)) begin
            estado_n = AGUARDA_BAIXA;
          end
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      AGUARDA_BAIXA: begin
        // Wait for AD to drop so a held request does not start another batch.
        if (!AD) begin
          estado_n = OCIOSO;
        end
      end
      default: begin
        estado_n = OCIOSO;
        if (AD && pode_liberar) begin
          estado_n = LIBERANDO;
          timer_n  = '0;
          lote_n   = '0;
        end
      end
    endcase
  end

  // State register with batch timer and batch counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
      timer  <= '0;
      lote   <= '0;
    end else begin
      estado <= estado_n;
      timer  <= timer_n;
      lote   <= lote_n;
    end
  end

  // Tray, stock and consume-error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bandeja      <= '0;
      estoque      <= STOCK_RST;
      erro_consumo <= 1'b0;
    end else begin
      bandeja      <= bandeja_n;
      estoque      <= estoque_n;
      erro_consumo <= erro_n;
    end
  end

  // Status flags decoded straight from registered values.
  always_comb begin
    BZ        = (bandeja == '0);
    CR        = (bandeja != '0) && (bandeja <= TRAY_LOW);
    ED        = (estoque == '0);
    liberando = (estado == LIBERANDO);
  end

endmodule

// File: tb/tb_dispensador_bandeja.sv
// Bench for dispensador_bandeja: directed stimulus queues hand-computed expectations,
// a monitor pops and compares them against the DUT away from the clock edge.
// Two instances: default parameters, and STOCK_INIT = 3 for the stock-exhaustion case.
module tb_dispensador_bandeja;

  logic       clk;
  logic       reset, reset3;
  logic       ad, ru, rf;
  logic [6:0] carga;
  logic       ad3, ru3, rf3;
  logic [6:0] carga3;

  logic       cr, bz, ed, lib, err;
  logic [4:0] band;
  logic [6:0] est;
  logic       cr3, bz3, ed3, lib3, err3;
  logic [4:0] band3;
  logic [6:0] est3;

  dispensador_bandeja dut (
    .clk(clk), .reset(reset), .AD(ad), .rolha_usada(ru), .reabastecer(rf), .carga(carga),
    .CR(cr), .BZ(bz), .ED(ed), .liberando(lib), .erro_consumo(err),
    .bandeja(band), .estoque(est)
  );

  dispensador_bandeja #(.STOCK_INIT(3)) dut3 (
    .clk(clk), .reset(reset3), .AD(ad3), .rolha_usada(ru3), .reabastecer(rf3), .carga(carga3),
    .CR(cr3), .BZ(bz3), .ED(ed3), .liberando(lib3), .erro_consumo(err3),
    .bandeja(band3), .estoque(est3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    bit    sel;
    string nome;
    int    band;
    int    est;
    bit    lib;
    bit    err;
  } exp_t;

  exp_t fila[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic kick    = 1'b0;

  // Queue one expectation for the current cycle; flags follow from the level definitions.
  task automatic esperar(string n, bit s, int b, int e, bit l, bit er);
    exp_t x;
    x.cyc = cyc; x.sel = s; x.nome = n; x.band = b; x.est = e; x.lib = l; x.err = er;
    fila.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every due expectation on the falling edge (or on an explicit kick).
  always @(negedge clk or kick) begin
    exp_t        x;
    logic [16:0] act, req;
    while (fila.size() > 0 && fila[0].cyc <= cyc) begin
      x = fila.pop_front();
      req = {(x.band > 0 && x.band <= 5), (x.band == 0), (x.est == 0), x.lib, x.err,
             5'(x.band), 7'(x.est)};
      if (x.sel) act = {cr3, bz3, ed3, lib3, err3, band3, est3};
      else       act = {cr, bz, ed, lib, err, band, est};
      n_tests++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got cr/bz/ed/lib/err=%b band=%0d est=%0d, need %b band=%0d est=%0d",
                 x.nome, cyc, act[16:12], act[11:7], act[6:0], req[16:12], req[11:7], req[6:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; reset3 = 1'b0;
    ad = 0; ru = 0; rf = 0; carga = '0;
    ad3 = 0; ru3 = 0; rf3 = 0; carga3 = '0;

    // Reset state, then idle with reset released.
    repeat (2) step();
    esperar("rst", 0, 0, 50, 0, 0);
    esperar("rst3", 1, 0, 3, 0, 0);
    reset = 1'b1;
    step();
    esperar("idle", 0, 0, 50, 0, 0);

    // First batch: 10 corks, one every 4 edges.
    ad = 1;
    step();
    esperar("entra1", 0, 0, 50, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      for (int t = 1; t <= 4; t++) begin
        step();
        if (t < 4) esperar("lib1", 0, k - 1, 51 - k, 1, 0);
        else       esperar("rolha1", 0, k, 50 - k, (k < 10), 0);
      end
    end
    repeat (3) begin
      step();
      esperar("segura", 0, 10, 40, 0, 0);
    end

    // Second batch stops on a full tray after 6 corks.
    ad = 0;
    step();
    esperar("baixa", 0, 10, 40, 0, 0);
    ad = 1;
    step();
    esperar("entra2", 0, 10, 40, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      repeat (4) step();
      esperar("rolha2", 0, 10 + k, 40 - k, (k < 6), 0);
    end
    step();
    ad = 0;
    step();
    ad = 1;
    repeat (2) step();
    esperar("cheia", 0, 16, 34, 0, 0);

    // Drain the tray, then consume once more on an empty tray.
    ad = 0; ru = 1;
    for (int i = 1; i <= 16; i++) begin
      step();
      esperar("consome", 0, 16 - i, 34, 0, 0);
    end
    step();
    esperar("erro", 0, 0, 34, 0, 1);
    ru = 0;
    step();
    esperar("erro_fim", 0, 0, 34, 0, 0);

    // Consume coincident with the sixth transfer at bandeja = 5.
    ad = 1;
    step();
    esperar("entra3", 0, 0, 34, 1, 0);
    ad = 0;
    repeat (20) step();
    esperar("cinco", 0, 5, 29, 1, 0);
    repeat (3) step();
    ru = 1;
    step();
    esperar("coinc", 0, 5, 28, 1, 0);
    ru = 0;
    repeat (16) step();
    esperar("fim3", 0, 9, 24, 0, 0);

    // Refill with saturation at 99.
    rf = 1; carga = 7'd71;
    step();
    esperar("refill95", 0, 9, 95, 0, 0);
    carga = 7'd10;
    step();
    esperar("refill_sat", 0, 9, 99, 0, 0);
    carga = 7'd127;
    step();
    esperar("refill_max", 0, 9, 99, 0, 0);
    rf = 0; carga = '0;

    // Async reset mid-batch with timer = 2.
    ad = 1;
    step();
    esperar("entra4", 0, 9, 99, 1, 0);
    repeat (2) step();
    esperar("timer2", 0, 9, 99, 1, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    esperar("rst_async", 0, 0, 50, 0, 0);
    kick = ~kick;
    #1;
    ad = 0;
    step();
    reset = 1'b1;
    step();
    esperar("pos_rst", 0, 0, 50, 0, 0);

    // Small stock: one-cycle AD pulse empties the stock after 3 corks.
    reset3 = 1'b1;
    step();
    esperar("idle3", 1, 0, 3, 0, 0);
    ad3 = 1;
    step();
    esperar("entra3b", 1, 0, 3, 1, 0);
    ad3 = 0;
    for (int k = 1; k <= 3; k++) begin
      repeat (4) step();
      esperar("rolha3b", 1, k, 3 - k, (k < 3), 0);
    end
    step();
    ad3 = 1;
    repeat (2) step();
    esperar("vazio_est", 1, 3, 0, 0, 0);
    rf3 = 1; carga3 = 7'd10;
    step();
    esperar("refill3", 1, 3, 10, 0, 0);
    rf3 = 0; carga3 = '0;
    step();
    esperar("aceita3", 1, 3, 10, 1, 0);
    ad3 = 0;

    step();
    @(negedge clk);
    #1;
    n_tests++;
    if (fila.size() != 0) begin
      n_fail++;
      $display("FAIL pendentes got %0d unchecked expectations, need 0", fila.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
